// File: rtl/ir_nec_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ir_nec_tx
// Brief    : NEC infrared frame transmitter with optional carrier modulation.
// Revision : 1.0
// ============================================================================
module ir_nec_tx #(
  parameter int CARRIER_HALF = 658,
  parameter int BIT_UNIT     = 28125,
  parameter int GAP_UNITS    = 72,
  parameter int CARRIER_EN   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic [7:0] cmd,
  output logic       ir_out,
  output logic       envelope,
  output logic       busy,
  output logic       done
);

  localparam int C_MAX_UNITS = (GAP_UNITS > 16) ? GAP_UNITS : 16;
  localparam int C_SEG_W     = $clog2(C_MAX_UNITS);
  localparam int C_UNIT_W    = $clog2(BIT_UNIT);
  localparam int C_CAR_W     = $clog2(CARRIER_HALF + 1);

  localparam logic [C_UNIT_W-1:0] C_UNIT_LAST = C_UNIT_W'(BIT_UNIT - 1);
  localparam logic [C_CAR_W-1:0]  C_CAR_LAST  = C_CAR_W'(CARRIER_HALF - 1);
  localparam logic [C_SEG_W-1:0]  C_GAP_LAST  = C_SEG_W'(GAP_UNITS - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LEAD_MARK  = 3'd1,
    S_LEAD_SPACE = 3'd2,
    S_BIT_MARK   = 3'd3,
    S_BIT_SPACE  = 3'd4,
    S_STOP_MARK  = 3'd5,
    S_GAP        = 3'd6
  } state_t;

  state_t              state_q;
  logic [31:0]         data_q;
  logic [4:0]          bit_q;
  logic [C_UNIT_W-1:0] unit_q;
  logic [C_SEG_W-1:0]  seg_q;
  logic [C_CAR_W-1:0]  car_q;
  logic                ir_q;
  logic                env_q;
  logic                busy_q;
  logic                done_q;

  logic [C_SEG_W-1:0]  w_seg_last;
  logic                w_unit_last;
  logic                w_seg_end;

  // Index of the last unit of the current state; a 1 bit stretches its space to 3 units.
  always_comb begin
    w_seg_last = '0;
    case (state_q)
      S_LEAD_MARK:  w_seg_last = C_SEG_W'(15);
      S_LEAD_SPACE: w_seg_last = C_SEG_W'(7);
      S_BIT_SPACE:  w_seg_last = data_q[bit_q] ? C_SEG_W'(2) : '0;
      S_GAP:        w_seg_last = C_GAP_LAST;
      default:      w_seg_last = '0;
    endcase
  end

  assign w_unit_last = (unit_q == C_UNIT_LAST);
  assign w_seg_end   = w_unit_last && (seg_q == w_seg_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      bit_q   <= '0;
      unit_q  <= '0;
      seg_q   <= '0;
      car_q   <= '0;
      ir_q    <= 1'b0;
      env_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == S_IDLE) begin
        unit_q <= '0;
        seg_q  <= '0;
        car_q  <= '0;
        if (start) begin
          data_q  <= {~cmd, cmd, ~addr, addr};
          bit_q   <= '0;
          state_q <= S_LEAD_MARK;
          busy_q  <= 1'b1;
          env_q   <= 1'b1;
          ir_q    <= 1'b1;
        end
      end else if (w_seg_end) begin
        // Every mark entry restarts the carrier phase so the mark opens high.
        unit_q <= '0;
        seg_q  <= '0;
        car_q  <= '0;
        case (state_q)
          S_LEAD_MARK: begin
            state_q <= S_LEAD_SPACE;
            env_q   <= 1'b0;
            ir_q    <= 1'b0;
          end
          S_LEAD_SPACE: begin
            state_q <= S_BIT_MARK;
            env_q   <= 1'b1;
            ir_q    <= 1'b1;
          end
          S_BIT_MARK: begin
            state_q <= S_BIT_SPACE;
            env_q   <= 1'b0;
            ir_q    <= 1'b0;
          end
          S_BIT_SPACE: begin
            state_q <= (bit_q == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
            bit_q   <= bit_q + 5'd1;
            env_q   <= 1'b1;
            ir_q    <= 1'b1;
          end
          S_STOP_MARK: begin
            state_q <= S_GAP;
            env_q   <= 1'b0;
            ir_q    <= 1'b0;
            done_q  <= 1'b1;
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            env_q   <= 1'b0;
            ir_q    <= 1'b0;
          end
        endcase
      end else begin
        if (w_unit_last) begin
          unit_q <= '0;
          seg_q  <= seg_q + 1'b1;
        end else begin
          unit_q <= unit_q + 1'b1;
        end
        if (env_q && (CARRIER_EN != 0)) begin
          if (car_q == C_CAR_LAST) begin
            car_q <= '0;
            ir_q  <= ~ir_q;
          end else begin
            car_q <= car_q + 1'b1;
          end
        end
      end
    end
  end

  assign ir_out   = ir_q;
  assign envelope = env_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
`default_nettype wire

// File: doc/ir_nec_tx.md
Name: ir_nec_tx

Overview:
- Downstream consumer of the keypad pulse generator: each one-cycle `start` pulse launches one NEC-format infrared frame on `ir_out`, which drives the IR LED.
- Encodes the address byte and the command byte. The command byte comes from the keypad-code mapping.
- Marks are modulated with a square-wave carrier, nominally 38 kHz.
- Single clock domain; all outputs registered.

Parameters:
- CARRIER_HALF, 658, clock cycles per carrier half-period (50 MHz / 38 kHz / 2). Must be ≥1.
- BIT_UNIT, 28125, clock cycles per NEC time unit (562.5 us at 50 MHz). Must be ≥2.
- GAP_UNITS, 72, time units of forced idle after the stop mark before a new `start` is accepted.
- CARRIER_EN, 1, 1 = modulate marks with the carrier; 0 = `ir_out` carries the raw envelope.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request pulse from the keypad pulse generator
- addr  input  8  device address
- cmd  input  8  command byte
- ir_out  output  1  modulated IR drive, active high
- envelope  output  1  unmodulated mark/space envelope, 1 = mark
- busy  output  1  high while a frame or its trailing gap is in progress
- done  output  1  one-cycle pulse when the stop mark ends

Behaviour:
- Reset is asynchronous, active-low (`rst_n`); `clk` is the only clock. While `rst_n` = 0:
  - state = IDLE, all counters = 0, latched data = 0
  - `ir_out`, `envelope`, `busy`, `done` all 0
- Reset asserted mid-frame aborts the frame immediately, with `ir_out` = 0 from the reset instant.
- Start acceptance:
  - `start` is sampled only in IDLE. On the accepting edge, latch the 32-bit payload {~cmd, cmd, ~addr, addr}.
  - Transmission order is LSB first: addr bits 0..7, ~addr, cmd, ~cmd.
  - `start` while `busy` = 1 is ignored, not queued.
  - Changes to `addr`/`cmd` after acceptance have no effect on the frame in progress.
- State sequence and durations, in clock cycles, with U = BIT_UNIT:
  - IDLE: waits for `start`.
  - LEAD_MARK: 16·U.
  - LEAD_SPACE: 8·U.
  - BIT_MARK: 1·U.
  - BIT_SPACE: 1·U for a 0 bit, 3·U for a 1 bit. BIT_MARK/BIT_SPACE repeat for 32 bits, driven by a 5-bit bit index; after index 31 go to STOP_MARK.
  - STOP_MARK: 1·U.
  - GAP: GAP_UNITS·U, then IDLE.
- Timing and latency:
  - Accepting edge t: state = LEAD_MARK and `busy` = 1 from cycle t+1.
  - `envelope` = 1 exactly in the MARK states, 0 elsewhere; state change and `envelope` change occur on the same edge.
  - `busy` falls on the edge that returns to IDLE. `start` may be accepted on that same edge's next cycle.
  - `done` is high for exactly the first cycle of GAP.
- Carrier:
  - Counter restarts at every mark entry, so `ir_out` = 1 in the first cycle of every mark.
  - `ir_out` toggles every CARRIER_HALF cycles while in a mark.
  - `ir_out` is forced to 0 in all non-mark states.
  - With CARRIER_EN = 0, `ir_out` = `envelope`.
- Counters:
  - Unit counter runs 0..BIT_UNIT-1 and wraps; the segment counter counts units per state.
  - Each state lasts exactly its stated duration; there is no off-by-one at state boundaries.
  - Counter widths are derived from the parameters via clog2.

Test Plan:
1. Reset: hold `rst_n` = 0 with `start` pulsing → all outputs 0. Release `rst_n` with no `start` → outputs stay 0 and state stays IDLE.
2. Full frame, with BIT_UNIT = 4, CARRIER_HALF = 1, GAP_UNITS = 2, addr = 8'h00, cmd = 8'h45:
   - `busy` high for 123·4 = 492 cycles.
   - The envelope decodes LSB first to 00 FF 45 BA.
   - `done` pulses at cycle 121·4 + 1 = 485 after acceptance.
3. Carrier check, same parameters: during LEAD_MARK, `ir_out` alternates 1,0,1,0… for 64 cycles. `ir_out` = 0 throughout the LEAD_SPACE 32-cycle window. With CARRIER_EN = 0, `ir_out` equals `envelope` every cycle.
4. Busy collision: issue a second `start` at cycle 100 (mid-frame) and again during GAP → both ignored, and exactly one frame is sent. A `start` issued the cycle after `busy` falls starts a new frame.
5. Data latching: change `cmd` from 8'h45 to 8'h16 two cycles after acceptance → the frame still carries 45/BA.
6. Mid-frame reset: assert `rst_n` = 0 during BIT_SPACE of bit 10 → `ir_out`, `envelope`, `busy` = 0 immediately. After release, a new `start` produces a complete, correct frame from the leader.
